// File: rtl/meas_result_tx.sv
// Serial transmitter for 16-bit measurement words: two UART byte frames, high byte first.
// Define MEAS_RESULT_TX_PARITY_EN to add an even-parity bit to each byte frame.
module meas_result_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset_ni,
  input  logic [15:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef MEAS_RESULT_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_next;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic        byte_idx;
  logic [15:0] data_q;
  logic [7:0]  cur_byte;
  logic        tx_next;
  logic        bit_end;
  logic        accept;

`ifdef MEAS_RESULT_TX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  assign accept   = valid_i && (state == IDLE);
  assign bit_end  = (cnt == 16'd0);
  assign cur_byte = byte_idx ? data_q[7:0] : data_q[15:8];
  assign ready_o  = (state == IDLE);
  assign busy_o   = (state != IDLE);
  assign done_o   = (state == STOP) && bit_end && byte_idx;

  // Next-state and next line level; tx_o itself is registered below.
  always_comb begin
    state_next = state;
    tx_next    = tx_o;
    case (state)
      IDLE: begin
        if (valid_i) begin
          state_next = START;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          tx_next    = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
`ifdef MEAS_RESULT_TX_PARITY_EN
            state_next = PARITY;
            tx_next    = even_parity(cur_byte);
`else
            state_next = STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            tx_next = cur_byte[bit_idx + 3'd1];
          end
        end
      end
`ifdef MEAS_RESULT_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_next = byte_idx ? IDLE : START;
          tx_next    = byte_idx;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // Control: state, line flop, bit timer and indices.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state    <= IDLE;
      tx_o     <= 1'b1;
      cnt      <= 16'd0;
      bit_idx  <= 3'd0;
      byte_idx <= 1'b0;
    end else begin
      state <= state_next;
      tx_o  <= tx_next;
      if (accept) begin
        cnt      <= RELOAD;
        bit_idx  <= 3'd0;
        byte_idx <= 1'b0;
      end else if (state != IDLE) begin
        if (bit_end) begin
          cnt <= RELOAD;
          if (state == DATA) bit_idx <= bit_idx + 3'd1;
          if (state == STOP) byte_idx <= !byte_idx;
        end else begin
          cnt <= cnt - 16'd1;
        end
      end
    end
  end

  // Word holding register: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) data_q <= data_i;
  end

endmodule

// File: tb/tb_meas_result_tx.sv
// Directed-plus-random bench for meas_result_tx; expected line bits come from a frame model.
module tb_meas_result_tx;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] data = 16'h0000;
  logic        ready, tx, busy, done;

  int total = 0;
  int passed = 0;
  bit exp_q[$];

  meas_result_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset_ni(reset_ni), .data_i(data), .valid_i(valid),
    .ready_o(ready), .tx_o(tx), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"}, {15'd0, tx}, 16'd1);
    chk({tag, "_ready"}, {15'd0, ready}, 16'd1);
    chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
    chk({tag, "_done"}, {15'd0, done}, 16'd0);
  endtask

  // Line sequence for one word: per byte (high first) start, 8 bits LSB first, [parity], stop.
  task automatic build_frame(input logic [15:0] w);
    logic [7:0] b;
    exp_q.delete();
    for (int n = 0; n < 2; n++) begin
      b = (n == 0) ? w[15:8] : w[7:0];
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
`ifdef MEAS_RESULT_TX_PARITY_EN
      exp_q.push_back(^b);
`endif
      exp_q.push_back(1'b1);
    end
  endtask

  // Called at a falling edge; acceptance happens on the next rising edge.
  task automatic send(input logic [15:0] w, input bit keep, input bit inject);
    int n;
    build_frame(w);
    n = exp_q.size() * CPB;
    chk("ready_before_accept", {15'd0, ready}, 16'd1);
    valid = 1'b1;
    data  = w;
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1 && !keep) valid = 1'b0;
      if (inject && k == 30) begin valid = 1'b1; data = 16'h1234; end
      if (inject && k == 34) begin valid = 1'b0; data = w; end
      chk("tx_bit", {15'd0, tx}, {15'd0, exp_q[(k-1)/CPB]});
      chk("busy_in_frame", {15'd0, busy}, 16'd1);
      chk("ready_in_frame", {15'd0, ready}, 16'd0);
      chk("done_timing", {15'd0, done}, (k == n) ? 16'd1 : 16'd0);
    end
    @(negedge clk);
    chk_idle("after_word");
  endtask

  initial begin
    logic [15:0] w;
    int g;

    repeat (3) begin @(negedge clk); chk_idle("in_reset"); end
    reset_ni = 1'b1;
    repeat (10) begin @(negedge clk); chk_idle("idle"); end

    send(16'hA55A, 1'b0, 1'b0);
    send(16'h0107, 1'b0, 1'b0);

    // Back-to-back with valid held: exactly one idle cycle between words.
    send(16'h0000, 1'b1, 1'b0);
    send(16'hFFFF, 1'b0, 1'b0);

    // Mid-frame request must be ignored.
    send(16'($urandom), 1'b0, 1'b1);

    for (int r = 0; r < 4; r++) begin
      g = $urandom_range(0, 3);
      repeat (g) begin @(negedge clk); chk_idle("gap"); end
      send(16'($urandom), 1'b0, 1'b0);
    end

    // Reset during data bit 3 of the first byte.
    w = 16'($urandom);
    build_frame(w);
    valid = 1'b1;
    data  = w;
    @(posedge clk);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) valid = 1'b0;
      chk("tx_before_reset", {15'd0, tx}, {15'd0, exp_q[(k-1)/CPB]});
    end
    reset_ni = 1'b0;
    #1;
    chk_idle("async_reset");
    repeat (2) begin @(negedge clk); chk_idle("held_reset"); end
    reset_ni = 1'b1;
    send(16'h00FF, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/meas_result_tx.md
MEAS_RESULT_TX -- requirements
Module: meas_result_tx

Interface
REQ-001 Parameter CLKS_PER_BIT SHALL default to 868 and set the clk cycles per serial bit (115200 baud at 100 MHz); legal range 2..65535.
REQ-002 Port clk  input  1  SHALL be the single clock; all flops update on its rising edge.
REQ-003 Port reset_ni  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port data_i  input  16  SHALL carry the measurement result word to transmit.
REQ-005 Port valid_i  input  1  SHALL qualify data_i.
REQ-006 Port ready_o  output  1  SHALL indicate the block can accept a word.
REQ-007 Port tx_o  output  1  SHALL be the serial line output, idle high.
REQ-008 Port busy_o  output  1  SHALL be high while a frame is on the line.
REQ-009 Port done_o  output  1  SHALL pulse high for one cycle when a word completes.

Function
REQ-010 Acceptance SHALL occur on a rising clk edge with valid_i=1 and ready_o=1; data_i SHALL be latched internally on that edge.
REQ-011 ready_o SHALL be 0 from the cycle after acceptance until the cycle after the last stop bit ends; valid_i while ready_o=0 SHALL be ignored with no side effects.
REQ-012 The word SHALL go out as two byte frames: data_i[15:8] first, then data_i[7:0], with no idle gap between them.
REQ-013 Each byte frame SHALL be 1 start bit (0), 8 data bits LSB first, optional parity bit (REQ-024), and 1 stop bit (1).
REQ-014 Each bit SHALL hold tx_o for exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded at each bit boundary.
REQ-015 tx_o SHALL be driven from a flop, and the start bit SHALL appear on tx_o in the cycle after acceptance.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, plus a byte-index flag and a 3-bit bit-index counter.
REQ-017 FSM transitions SHALL be: IDLE->START on acceptance; START->DATA after one bit; DATA->PARITY (macro defined) or STOP after bit 7; PARITY->STOP; STOP->START when byte index=0; STOP->IDLE when byte index=1.
REQ-018 done_o SHALL assert in the cycle where STOP->IDLE occurs, and ready_o SHALL rise in the following cycle.
REQ-019 busy_o SHALL equal (state != IDLE).
REQ-020 Total word time SHALL be 20*CLKS_PER_BIT cycles without parity and 22*CLKS_PER_BIT cycles with parity.
REQ-021 If valid_i is held high continuously, back-to-back words SHALL be accepted on the first ready_o=1 edge, giving exactly one idle-high cycle between words.

Reset
REQ-022 Asserting reset_ni low SHALL immediately force tx_o=1, ready_o=1, busy_o=0, done_o=0, state=IDLE and zero all counters, including mid-frame; no partial frame SHALL resume afterwards.
REQ-023 After reset_ni deasserts, the first acceptance SHALL be possible on the first rising clk edge.

Configuration
REQ-024 With MEAS_RESULT_TX_PARITY_EN defined, each byte frame SHALL insert an even-parity bit (XOR of the 8 data bits) between bit 7 and the stop bit; undefined, the PARITY state and its logic SHALL be absent and frames SHALL be 10 bits long.

Verification (CLKS_PER_BIT=4)
REQ-025 Reset, idle 10 cycles -> tx_o=1, ready_o=1, busy_o=0, done_o=0 throughout.
REQ-026 Send 0xA55A without parity -> tx_o per bit: 0,1,0,1,0,0,1,0,1,1 then 0,0,1,0,1,1,0,1,0,1; each bit 4 cycles; done_o pulses at cycle 80 after acceptance.
REQ-027 Same word with MEAS_RESULT_TX_PARITY_EN -> parity bit 0 after each byte; done_o at cycle 88; send 0x0107 -> parity bits 1 then 1.
REQ-028 Hold valid_i=1 with data 0x0000 then 0xFFFF -> second acceptance exactly 1 cycle after ready_o rises; one idle-high cycle between frames.
REQ-029 Pulse valid_i with 0x1234 mid-frame -> ignored; the line carries only the original word.
REQ-030 Assert reset_ni during data bit 3 of the first byte -> tx_o=1 without waiting for a clk edge; after release, send 0x00FF -> clean, complete frame.
